rv_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M funct3 operation set for the pipelined core's execute stage. A Start pulse launches an operation on two XLEN-bit operands. The unit holds Busy, which the hazard logic uses to stall the fetch, decode and execute stages, and it pulses Done with a registered Result. It generalises the single-cycle ALU path to any XLEN, and it adds a selectable fast path for divide special cases.

---
 rtl/rv_muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// A Start pulse (sampled in IDLE or DONE) launches the operation selected by
// Funct3 on operands A and B. Busy stalls the pipeline while the iterative
// datapath runs. Done pulses for one cycle when Result holds the answer.
//
// Ports:
//   CLK     clock, rising edge
//   RST     asynchronous active-low reset
//   Start   launch request
//   Funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   A, B    rs1 / rs2 operands, sampled with Start
//   Flush   synchronous abort; wins over Start
//   Busy    high in RUN and FIX
//   Done    one-cycle completion pulse
//   Result  registered result; holds until the next accepted Start
module rv_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              b_zero_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    // Operand decode at accept time
    logic            in_signed_a;
    logic            in_signed_b;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
    logic            in_b_zero;
    logic            accept;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        // MULHU, DIVU and REMU are fully unsigned; MULHSU signs only A
        in_signed_a = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
        in_signed_b = in_signed_a && (Funct3 != 3'b010);
        in_sign_a   = in_signed_a & A[XLEN-1];
        in_sign_b   = in_signed_b & B[XLEN-1];
        in_mag_a    = in_sign_a ? (~A + 1'b1) : A;
        in_mag_b    = in_sign_b ? (~B + 1'b1) : B;
        in_b_zero   = (B == '0);
        accept      = Start && !Flush && ((state == S_IDLE) || (state == S_DONE));
        fast        = (EARLY_OUT != 0) && Funct3[2] &&
                      (in_b_zero || (!Funct3[0] && (A == MIN_VAL) && (B == '1)));
        // Divide-by-zero takes priority; otherwise this is MIN / -1
        if (Funct3[1]) begin
            fast_result = in_b_zero ? A : '0;
        end else begin
            fast_result = in_b_zero ? '1 : MIN_VAL;
        end
    end

    // One iteration of the shared datapath. Both algorithms start from
    // acc = {0, |A|}: multiply accumulates into the upper half while shifting
    // the multiplier out of the bottom; divide treats the upper half as the
    // partial remainder and shifts quotient bits into the bottom.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (!op_q[2]) begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            // No borrow: divisor fits, keep the difference
            step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = ((sign_a_q ^ sign_b_q) && !b_zero_q) ?
                   (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                Busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                Done = 1'b1;
                if (accept) begin
                    state_next = fast ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (Flush) begin
            state_next = S_IDLE;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= Funct3;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            b_zero_q <= in_b_zero;
            mag_b_q  <= in_mag_b;
            acc_q    <= {{XLEN{1'b0}}, in_mag_a};
            cnt_q    <= '0;
            if (fast) begin
                result_q <= fast_result;
            end
        end else if (!Flush) begin
            if (state == S_RUN) begin
                acc_q <= step;
                cnt_q <= cnt_q + CW'(1);
            end else if (state == S_FIX) begin
                result_q <= fix_result;
            end
        end
    end

    assign Result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit (XLEN=32). Two instances share all
// inputs: dut_f with the divide fast path enabled, dut_s without it.
module tb_rv_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        flush;

    logic        busy_f, done_f, busy_s, done_s;
    logic [31:0] result_f, result_s;

    int total;
    int bad;

    rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) dut_f (
        .CLK(clk), .RST(rst), .Start(start), .Funct3(funct3), .A(a_in), .B(b_in),
        .Flush(flush), .Busy(busy_f), .Done(done_f), .Result(result_f)
    );

    rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(0)) dut_s (
        .CLK(clk), .RST(rst), .Start(start), .Funct3(funct3), .A(a_in), .B(b_in),
        .Flush(flush), .Busy(busy_s), .Done(done_s), .Result(result_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: launches an op, then watches 40 cycles.
    // Cycle index n=0 is the cycle right after the Start edge.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_f);
        int first_f, first_s, pulses_f, pulses_s, bcnt_f, bcnt_s, both;
        logic [31:0] res_f, res_s;
        first_f = -1; first_s = -1; pulses_f = 0; pulses_s = 0;
        bcnt_f = 0; bcnt_s = 0; both = 0;
        res_f = 'x; res_s = 'x;
        funct3 = f; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done_f) begin
                if (first_f < 0) begin first_f = n; res_f = result_f; end
                pulses_f++;
            end
            if (done_s) begin
                if (first_s < 0) begin first_s = n; res_s = result_s; end
                pulses_s++;
            end
            if (busy_f) bcnt_f++;
            if (busy_s) bcnt_s++;
            if ((busy_f && done_f) || (busy_s && done_s)) both++;
            @(negedge clk);
        end
        check({tag, "_res_f"}, 64'(res_f), 64'(exp));
        check({tag, "_res_s"}, 64'(res_s), 64'(exp));
        check({tag, "_lat_f"}, 64'(first_f), 64'(lat_f));
        check({tag, "_lat_s"}, 64'(first_s), 64'(33));
        check({tag, "_pulses_f"}, 64'(pulses_f), 64'(1));
        check({tag, "_pulses_s"}, 64'(pulses_s), 64'(1));
        check({tag, "_busy_f"}, 64'(bcnt_f), (lat_f == 0) ? 64'(0) : 64'(33));
        check({tag, "_busy_s"}, 64'(bcnt_s), 64'(33));
        check({tag, "_overlap"}, 64'(both), 64'(0));
        check({tag, "_hold_f"}, 64'(result_f), 64'(exp));
    endtask

    initial begin
        int seen;
        int dcount;
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; a_in = '0; b_in = '0;

        #12;
        check("rst_busy_f", 64'(busy_f), 64'(0));
        check("rst_done_f", 64'(done_f), 64'(0));
        check("rst_result_f", 64'(result_f), 64'(0));
        check("rst_busy_s", 64'(busy_s), 64'(0));
        check("rst_done_s", 64'(done_s), 64'(0));
        check("rst_result_s", 64'(result_s), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("mul",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("div",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu",     3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33);
        run_op("remu",     3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 33);
        run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("div_z",    3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_z",    3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0);
        run_op("divu_z",   3'b101, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("remu_z",   3'b111, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 0);

        // Flush mid-DIVU: no Done, Result keeps 9
        funct3 = 3'b101; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy_s), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_f", 64'(busy_f), 64'(0));
        check("flush_busy_s", 64'(busy_s), 64'(0));
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            if (done_f || done_s || busy_f || busy_s) dcount++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(dcount), 64'(0));
        check("flush_res_f", 64'(result_f), 64'(32'd9));
        check("flush_res_s", 64'(result_s), 64'(32'd9));

        // Back-to-back: new Start issued in the Done cycle of MUL 3*5
        funct3 = 3'b000; a_in = 32'd3; b_in = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && !done_s; n++) @(negedge clk);
        if (done_s) seen = 1;
        check("b2b_first_done", 64'(seen), 64'(1));
        check("b2b_first_res", 64'(result_s), 64'(32'd15));
        run_op("b2b_second", 3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33);

        // Asynchronous reset between edges mid-MULHU
        funct3 = 3'b011; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy_f", 64'(busy_f), 64'(0));
        check("arst_done_f", 64'(done_f), 64'(0));
        check("arst_result_f", 64'(result_f), 64'(0));
        check("arst_busy_s", 64'(busy_s), 64'(0));
        check("arst_done_s", 64'(done_s), 64'(0));
        check("arst_result_s", 64'(result_s), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
